// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I decode stage.
//   - opcode constants for the supported instruction classes
//   - ALU_Control codes consumed by execute
//   - decode_t: everything the combinational decoder extracts from one word
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'h00,
    ALU_SUB  = 6'h01,
    ALU_AND  = 6'h02,
    ALU_OR   = 6'h03,
    ALU_XOR  = 6'h04,
    ALU_SLT  = 6'h05,
    ALU_SLTU = 6'h06,
    ALU_SLL  = 6'h07,
    ALU_SRL  = 6'h08,
    ALU_SRA  = 6'h09,
    ALU_LUI  = 6'h0A,
    ALU_BEQ  = 6'h10,
    ALU_BNE  = 6'h11,
    ALU_BLT  = 6'h14,
    ALU_BGE  = 6'h15,
    ALU_BLTU = 6'h16,
    ALU_BGEU = 6'h17,
    ALU_JAL  = 6'h18
  } alu_op_e;

  // Instruction-level view: field widths are fixed by the RV32I encoding,
  // the stage widens them to its own parameters.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        is_imm;
    logic        is_wb;
    logic        illegal;
  } decode_t;

  // Shared by R-type and I-type arithmetic; alt selects SUB/SRA and is
  // only meaningful for funct3 000 and 101.
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    unique case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: 2**REG_AW x XLEN, one write port, two asynchronous read ports.
//   clock                     write clock
//   w_regfile/sel_regfile/data_regfile  write port (writes to index 0 ignored)
//   rd_sel1/rd_sel2 -> rd_data1/rd_data2 combinational reads (pre-write value)
module regfile #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              w_regfile,
  input  logic [REG_AW-1:0] sel_regfile,
  input  logic [XLEN-1:0]   data_regfile,
  input  logic [REG_AW-1:0] rd_sel1,
  input  logic [REG_AW-1:0] rd_sel2,
  output logic [XLEN-1:0]   rd_data1,
  output logic [XLEN-1:0]   rd_data2
);

  logic [XLEN-1:0] regs [2**REG_AW];

  // NOTE: the storage array is deliberately not reset; a reset would turn the
  // RAM into a flop bank. Software initialises registers before reading them,
  // and index 0 is masked to zero by the reader.
  always_ff @(posedge clock) begin
    if (w_regfile && (sel_regfile != '0)) begin
      regs[sel_regfile] <= data_regfile;
    end
  end

  assign rd_data1 = regs[rd_sel1];
  assign rd_data2 = regs[rd_sel2];

endmodule

// File: rtl/rv_instr_decoder.sv
// Pure combinational RV32I decoder.
//   instr : 32-bit instruction word
//   dec   : register fields (0 when unused), sign-extended immediate,
//           ALU op, class flags and source-usage flags.
// Unsupported opcodes, and load/store/branch funct3 values outside the
// supported set, decode as illegal with every other field zero.
module rv_instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        has_rd;
  logic        bad_funct;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    dec       = '0;
    has_rd    = 1'b0;
    bad_funct = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        has_rd       = 1'b1;
        dec.alu      = arith_op(funct3, instr[30]);
      end
      OP_I: begin
        dec.uses_rs1 = 1'b1;
        has_rd       = 1'b1;
        dec.is_imm   = 1'b1;
        dec.imm      = imm_i;
        // Only srai carries the alt bit; addi has no subtract form.
        dec.alu      = arith_op(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OP_LOAD: begin
        dec.uses_rs1 = 1'b1;
        has_rd       = 1'b1;
        dec.is_load  = 1'b1;
        dec.imm      = imm_i;
        bad_funct    = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.is_store = 1'b1;
        dec.imm      = imm_s;
        bad_funct    = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        unique case (funct3)
          3'b000:  dec.alu = ALU_BEQ;
          3'b001:  dec.alu = ALU_BNE;
          3'b100:  dec.alu = ALU_BLT;
          3'b101:  dec.alu = ALU_BGE;
          3'b110:  dec.alu = ALU_BLTU;
          3'b111:  dec.alu = ALU_BGEU;
          default: bad_funct = 1'b1;
        endcase
      end
      OP_LUI: begin
        has_rd     = 1'b1;
        dec.is_imm = 1'b1;
        dec.imm    = imm_u;
        dec.alu    = ALU_LUI;
      end
      OP_JAL: begin
        has_rd      = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm     = imm_j;
        dec.alu     = ALU_JAL;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (bad_funct) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else if (!dec.illegal) begin
      dec.rs1   = dec.uses_rs1 ? instr[19:15] : 5'd0;
      dec.rs2   = dec.uses_rs2 ? instr[24:20] : 5'd0;
      dec.rd    = has_rd ? instr[11:7] : 5'd0;
      dec.is_wb = has_rd && (instr[11:7] != 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage_hs.sv
// Handshaked RV32I decode stage between fetch and execute.
//   clock, reset (sync, active-high)
//   w_regfile/sel_regfile/data_regfile : WB write port, optionally bypassed
//   br_en    : redirect, squashes the output register and the current fetch word
//   fd_valid/fd_pc/fd_instr, fd_ready  : fetch-side handshake
//   ex_ready, da_valid                 : execute-side handshake
//   da_*     : registered decoded instruction (operands, imm, target, flags)
// One output register; a load in it stalls a directly dependent fetch word
// for one cycle (a bubble is issued instead).
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_regfile,
  input  logic [REG_AW-1:0] sel_regfile,
  input  logic [XLEN-1:0]   data_regfile,
  input  logic              br_en,
  input  logic              fd_valid,
  input  logic [XLEN-1:0]   fd_pc,
  input  logic [31:0]       fd_instr,
  output logic              fd_ready,
  input  logic              ex_ready,
  output logic              da_valid,
  output logic [XLEN-1:0]   da_pc,
  output logic [XLEN-1:0]   da_target_PC,
  output logic [REG_AW-1:0] da_read_sel1,
  output logic [REG_AW-1:0] da_read_sel2,
  output logic [REG_AW-1:0] da_write_sel,
  output logic [XLEN-1:0]   da_data1,
  output logic [XLEN-1:0]   da_data2,
  output logic [XLEN-1:0]   da_imm32,
  output logic [5:0]        da_ALU_Control,
  output logic              da_is_branch,
  output logic              da_is_jump,
  output logic              da_is_load,
  output logic              da_is_store,
  output logic              da_is_imm,
  output logic              da_is_wb,
  output logic              da_illegal
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   target;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic [XLEN-1:0]   imm;
    logic [5:0]        alu;
    logic              is_branch;
    logic              is_jump;
    logic              is_load;
    logic              is_store;
    logic              is_imm;
    logic              is_wb;
    logic              illegal;
  } entry_t;

  decode_t           dec;
  entry_t            da_q, da_d;
  logic [REG_AW-1:0] rs1_sel, rs2_sel;
  logic [XLEN-1:0]   rf_data1, rf_data2, imm_x;
  logic              hazard, advance, load_en;

  rv_instr_decoder u_decoder (
    .instr (fd_instr),
    .dec   (dec)
  );

  assign rs1_sel = REG_AW'(dec.rs1);
  assign rs2_sel = REG_AW'(dec.rs2);
  assign imm_x   = XLEN'($signed(dec.imm));

  regfile #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clock        (clock),
    .w_regfile    (w_regfile),
    .sel_regfile  (sel_regfile),
    .data_regfile (data_regfile),
    .rd_sel1      (rs1_sel),
    .rd_sel2      (rs2_sel),
    .rd_data1     (rf_data1),
    .rd_data2     (rf_data2)
  );

  // x0 reads as zero; a WB landing this very cycle beats the stale array value.
  function automatic logic [XLEN-1:0] read_operand(input logic [REG_AW-1:0] sel,
                                                   input logic [XLEN-1:0]   rf_value);
    if (sel == '0) return '0;
    if (WB_BYPASS && w_regfile && (sel_regfile == sel)) return data_regfile;
    return rf_value;
  endfunction

  // Unused source fields decode as 0 and da_q.rd is nonzero here, so the
  // field compare alone implies the source is actually used.
  assign hazard = fd_valid && da_q.valid && da_q.is_load && (da_q.rd != '0) &&
                  ((dec.uses_rs1 && (rs1_sel == da_q.rd)) ||
                   (dec.uses_rs2 && (rs2_sel == da_q.rd)));

  assign advance  = !da_q.valid || ex_ready;
  assign load_en  = advance && fd_valid && !hazard;
  assign fd_ready = !reset && !hazard && advance;

  always_comb begin
    da_d           = '0;
    da_d.valid     = 1'b1;
    da_d.pc        = fd_pc;
    da_d.target    = fd_pc + imm_x;
    da_d.rs1       = rs1_sel;
    da_d.rs2       = rs2_sel;
    da_d.rd        = REG_AW'(dec.rd);
    da_d.data1     = read_operand(rs1_sel, rf_data1);
    da_d.data2     = read_operand(rs2_sel, rf_data2);
    da_d.imm       = imm_x;
    da_d.alu       = dec.alu;
    da_d.is_branch = dec.is_branch;
    da_d.is_jump   = dec.is_jump;
    da_d.is_load   = dec.is_load;
    da_d.is_store  = dec.is_store;
    da_d.is_imm    = dec.is_imm;
    da_d.is_wb     = dec.is_wb;
    da_d.illegal   = dec.illegal;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  // Priority: reset, then redirect, then advance (load or bubble), else hold.
  always_ff @(posedge clock) begin
    if (reset || br_en || (advance && !load_en)) begin
      da_q <= '0;
    end else if (load_en) begin
      da_q <= da_d;
    end
  end

  assign da_valid       = da_q.valid;
  assign da_pc          = da_q.pc;
  assign da_target_PC   = da_q.target;
  assign da_read_sel1   = da_q.rs1;
  assign da_read_sel2   = da_q.rs2;
  assign da_write_sel   = da_q.rd;
  assign da_data1       = da_q.data1;
  assign da_data2       = da_q.data2;
  assign da_imm32       = da_q.imm;
  assign da_ALU_Control = da_q.alu;
  assign da_is_branch   = da_q.is_branch;
  assign da_is_jump     = da_q.is_jump;
  assign da_is_load     = da_q.is_load;
  assign da_is_store    = da_q.is_store;
  assign da_is_imm      = da_q.is_imm;
  assign da_is_wb       = da_q.is_wb;
  assign da_illegal     = da_q.illegal;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: an instruction-level reference
// model tracks what the output register must hold every cycle, plus literal
// expectations for the directed scenarios.
module tb_decode_stage_hs;

  logic        clock = 1'b0;
  logic        reset;
  logic        w_regfile;
  logic [4:0]  sel_regfile;
  logic [31:0] data_regfile;
  logic        br_en;
  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_ready;
  logic        ex_ready;
  logic        da_valid;
  logic [31:0] da_pc, da_target_PC;
  logic [4:0]  da_read_sel1, da_read_sel2, da_write_sel;
  logic [31:0] da_data1, da_data2, da_imm32;
  logic [5:0]  da_ALU_Control;
  logic        da_is_branch, da_is_jump, da_is_load, da_is_store;
  logic        da_is_imm, da_is_wb, da_illegal;

  decode_stage_hs dut (
    .clock          (clock),
    .reset          (reset),
    .w_regfile      (w_regfile),
    .sel_regfile    (sel_regfile),
    .data_regfile   (data_regfile),
    .br_en          (br_en),
    .fd_valid       (fd_valid),
    .fd_pc          (fd_pc),
    .fd_instr       (fd_instr),
    .fd_ready       (fd_ready),
    .ex_ready       (ex_ready),
    .da_valid       (da_valid),
    .da_pc          (da_pc),
    .da_target_PC   (da_target_PC),
    .da_read_sel1   (da_read_sel1),
    .da_read_sel2   (da_read_sel2),
    .da_write_sel   (da_write_sel),
    .da_data1       (da_data1),
    .da_data2       (da_data2),
    .da_imm32       (da_imm32),
    .da_ALU_Control (da_ALU_Control),
    .da_is_branch   (da_is_branch),
    .da_is_jump     (da_is_jump),
    .da_is_load     (da_is_load),
    .da_is_store    (da_is_store),
    .da_is_imm      (da_is_imm),
    .da_is_wb       (da_is_wb),
    .da_illegal     (da_illegal)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, target, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  alu;
    logic        br, jmp, ld, st, im, wb, ill;
  } exp_t;

  exp_t        m;
  logic [31:0] shadow [32];

  function automatic logic [31:0] opval(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (w_regfile && sel_regfile == r) return data_regfile;
    return shadow[r];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [5:0]  arith [8];
    logic [2:0]  f3;
    int          imm;
    bit          r1, r2, rdu, ok;
    arith = '{6'h00, 6'h07, 6'h05, 6'h06, 6'h04, 6'h08, 6'h03, 6'h02};
    e = '0; f3 = ins[14:12]; imm = 0; r1 = 0; r2 = 0; rdu = 0; ok = 1;
    case (ins[6:0])
      7'h33: begin
        r1 = 1; r2 = 1; rdu = 1; e.alu = arith[f3];
        if (ins[30] && f3 == 3'd0) e.alu = 6'h01;
        if (ins[30] && f3 == 3'd5) e.alu = 6'h09;
      end
      7'h13: begin
        r1 = 1; rdu = 1; e.im = 1; imm = int'($signed(ins)) >>> 20; e.alu = arith[f3];
        if (ins[30] && f3 == 3'd5) e.alu = 6'h09;
      end
      7'h03: begin ok = (f3 == 3'd2); r1 = 1; rdu = 1; e.ld = 1; imm = int'($signed(ins)) >>> 20; end
      7'h23: begin
        ok = (f3 == 3'd2); r1 = 1; r2 = 1; e.st = 1;
        imm = (int'($signed(ins)) >>> 25) * 32 + int'(ins[11:7]);
      end
      7'h63: begin
        ok = (f3 != 3'd2 && f3 != 3'd3); r1 = 1; r2 = 1; e.br = 1; e.alu = 6'h10 + 6'(f3);
        imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'h37: begin rdu = 1; e.im = 1; e.alu = 6'h0A; imm = int'(ins & 32'hFFFF_F000); end
      7'h6F: begin
        rdu = 1; e.jmp = 1; e.alu = 6'h18;
        imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
              int'(ins[30:21]) * 2;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0; e.ill = 1;
    end else begin
      e.imm = 32'(imm);
      e.rs1 = r1 ? ins[19:15] : 5'd0;
      e.rs2 = r2 ? ins[24:20] : 5'd0;
      e.rd  = rdu ? ins[11:7] : 5'd0;
      e.wb  = rdu && (ins[11:7] != 5'd0);
    end
    e.valid  = 1;
    e.pc     = pc;
    e.target = pc + e.imm;
    e.d1     = opval(e.rs1);
    e.d2     = opval(e.rs2);
    return e;
  endfunction

  function automatic bit model_hazard();
    exp_t f;
    f = ref_decode(fd_instr, fd_pc);
    return fd_valid && m.valid && m.ld && (m.rd != 5'd0) &&
           ((f.rs1 == m.rd) || (f.rs2 == m.rd));
  endfunction

  always @(posedge clock) begin
    bit hz, adv;
    hz  = model_hazard();
    adv = !m.valid || ex_ready;
    if (reset || br_en)        m = '0;
    else if (adv) m = (fd_valid && !hz) ? ref_decode(fd_instr, fd_pc) : '0;
    if (w_regfile && sel_regfile != 5'd0) shadow[sel_regfile] = data_regfile;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("fd_ready", 32'(fd_ready), 32'(!reset && !model_hazard() && (!m.valid || ex_ready)));
      check("da_valid", 32'(da_valid), 32'(m.valid));
      check("da_pc", da_pc, m.pc);
      check("da_target_PC", da_target_PC, m.target);
      check("da_read_sel1", 32'(da_read_sel1), 32'(m.rs1));
      check("da_read_sel2", 32'(da_read_sel2), 32'(m.rs2));
      check("da_write_sel", 32'(da_write_sel), 32'(m.rd));
      check("da_data1", da_data1, m.d1);
      check("da_data2", da_data2, m.d2);
      check("da_imm32", da_imm32, m.imm);
      check("da_ALU_Control", 32'(da_ALU_Control), 32'(m.alu));
      check("da_flags", 32'({da_is_branch, da_is_jump, da_is_load, da_is_store,
                             da_is_imm, da_is_wb, da_illegal}),
            32'({m.br, m.jmp, m.ld, m.st, m.im, m.wb, m.ill}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fd(input bit v, input logic [31:0] pc, input logic [31:0] ins);
    fd_valid = v; fd_pc = pc; fd_instr = ins;
  endtask

  logic [31:0] prog [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries, cyc;
    prog = '{32'h402084B3, 32'h4020D533, 32'h0020B5B3, 32'hFFF0C613,
             32'h4030D693, 32'h12345737, 32'h0020F863, 32'h00412783,
             32'h00F1A023, 32'h00108033, 32'h0000A003, 32'h00000233};
    reset = 1; w_regfile = 0; sel_regfile = 0; data_regfile = 0; br_en = 0;
    ex_ready = 1; set_fd(0, 0, 0);
    next();
    cmp_en = 1;
    @(negedge clock);
    check("reset_da_valid", 32'(da_valid), 32'd0);
    check("reset_fd_ready", 32'(fd_ready), 32'd0);
    next();
    reset = 0;
    for (int i = 1; i < 32; i++) begin
      w_regfile = 1; sel_regfile = 5'(i); data_regfile = 32'h1000_0000 | 32'(i << 8) | 32'(i);
      next();
    end
    w_regfile = 0;

    // addi x1,x0,5 ; add x2,x1,x1 back to back
    set_fd(1, 32'h0, 32'h00500093);
    @(negedge clock); check("t2_ready0", 32'(fd_ready), 32'd1);
    next();
    set_fd(1, 32'h4, 32'h00108133);
    @(negedge clock);
    check("t2_addi_valid", 32'(da_valid), 32'd1);
    check("t2_addi_imm", da_imm32, 32'd5);
    check("t2_addi_rd", 32'(da_write_sel), 32'd1);
    check("t2_ready1", 32'(fd_ready), 32'd1);
    next();
    set_fd(0, 0, 0);
    @(negedge clock);
    check("t2_add_pc", da_pc, 32'h4);
    check("t2_add_data1", da_data1, 32'h1000_0101);
    next();

    // lw x3,0(x1) ; add x4,x3,x3 -> one bubble
    set_fd(1, 32'h8, 32'h0000A183);
    next();
    set_fd(1, 32'hC, 32'h00318233);
    @(negedge clock);
    check("t3_hazard_ready", 32'(fd_ready), 32'd0);
    check("t3_is_load", 32'(da_is_load), 32'd1);
    next();
    @(negedge clock);
    check("t3_bubble", 32'(da_valid), 32'd0);
    check("t3_ready_after", 32'(fd_ready), 32'd1);
    next();
    set_fd(0, 0, 0);
    @(negedge clock);
    check("t3_add_valid", 32'(da_valid), 32'd1);
    check("t3_add_pc", da_pc, 32'hC);
    next();

    // ex_ready low for 3 cycles
    set_fd(1, 32'h10, 32'h00300393);
    next();
    ex_ready = 0;
    set_fd(1, 32'h14, 32'h00738433);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t4_hold_pc", da_pc, 32'h10);
      check("t4_hold_imm", da_imm32, 32'd3);
      check("t4_hold_ready", 32'(fd_ready), 32'd0);
      next();
    end
    ex_ready = 1;
    @(negedge clock); check("t4_resume_ready", 32'(fd_ready), 32'd1);
    next();
    set_fd(0, 0, 0);
    @(negedge clock);
    check("t4_next_pc", da_pc, 32'h14);
    check("t4_next_valid", 32'(da_valid), 32'd1);
    next();
    @(negedge clock); check("t4_drained", 32'(da_valid), 32'd0);
    next();

    // branch redirect squashes
    set_fd(1, 32'h20, 32'h00500093); br_en = 1;
    next();
    br_en = 0; set_fd(0, 0, 0);
    @(negedge clock); check("t5_squash_fetch", 32'(da_valid), 32'd0);
    next();
    set_fd(1, 32'h24, 32'h00500093);
    next();
    set_fd(0, 0, 0); ex_ready = 0; br_en = 1;
    @(negedge clock); check("t5_pre_squash_pc", da_pc, 32'h24);
    next();
    br_en = 0;
    @(negedge clock); check("t5_squash_stalled", 32'(da_valid), 32'd0);
    ex_ready = 1;
    next();

    // reset mid-stream for 2 cycles
    set_fd(1, 32'h30, 32'h00500093);
    next();
    set_fd(1, 32'h34, 32'h00108133); reset = 1;
    @(negedge clock); check("t1_ready_in_reset", 32'(fd_ready), 32'd0);
    next();
    @(negedge clock);
    check("t1_reset_valid", 32'(da_valid), 32'd0);
    check("t1_reset_pc", da_pc, 32'd0);
    check("t1_reset_imm", da_imm32, 32'd0);
    next();
    reset = 0;
    @(negedge clock); check("t1_release_ready", 32'(fd_ready), 32'd1);
    next();
    set_fd(0, 0, 0);
    @(negedge clock); check("t1_first_pc", da_pc, 32'h34);
    next();

    // WB bypass, branch target, illegal, JAL wrap, store
    w_regfile = 1; sel_regfile = 5'd5; data_regfile = 32'hDEAD_BEEF;
    set_fd(1, 32'h40, 32'h00028333);
    next();
    w_regfile = 0;
    set_fd(1, 32'h100, 32'hFE208CE3);
    @(negedge clock);
    check("t6_bypass_data1", da_data1, 32'hDEAD_BEEF);
    check("t6_bypass_data2", da_data2, 32'd0);
    next();
    set_fd(1, 32'h104, 32'h0000007F);
    @(negedge clock);
    check("t6_beq_target", da_target_PC, 32'hF8);
    check("t6_beq_imm", da_imm32, 32'hFFFF_FFF8);
    check("t6_beq_alu", 32'(da_ALU_Control), 32'h10);
    next();
    set_fd(1, 32'hFFFF_FFF0, 32'h020000EF);
    @(negedge clock);
    check("t6_illegal", 32'(da_illegal), 32'd1);
    check("t6_illegal_valid", 32'(da_valid), 32'd1);
    check("t6_illegal_flags", 32'({da_is_branch, da_is_wb, da_is_imm}), 32'd0);
    next();
    set_fd(1, 32'h200, 32'h0020A423);
    @(negedge clock);
    check("t6_jal_wrap", da_target_PC, 32'h10);
    check("t6_jal_alu", 32'(da_ALU_Control), 32'h18);
    next();
    set_fd(0, 0, 0);
    @(negedge clock);
    check("t6_sw_store", 32'(da_is_store), 32'd1);
    check("t6_sw_rd", 32'(da_write_sel), 32'd0);
    check("t6_sw_imm", da_imm32, 32'd8);
    next();

    // mixed program with a periodic execute stall
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      set_fd(1, 32'h300 + 32'(4 * i), prog[i]);
      tries = 0;
      acc   = 0;
      do begin
        ex_ready = (cyc % 3) != 2;
        cyc++;
        @(negedge clock);
        acc = fd_ready;
        next();
        tries++;
      end while (!acc && tries < 20);
      check("prog_accept", 32'(acc), 32'd1);
    end
    set_fd(0, 0, 0); ex_ready = 1;
    repeat (3) next();
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
